// File: rtl/rd_reorder_buffer_pkg.sv
// rtl/rd_reorder_buffer_pkg.sv - tag types and pack/unpack helpers for the read reorder buffer
//  ROB_EPOCH_W     : width of the flush epoch carried in every tag
//  t_rob_tag       : mdata as seen on the c0 channel, {pad, epoch, slot}
//  t_rob_tag_fields: decoded view of a tag (foreign pad flag, epoch, slot)
//  tag_pack()      : build mdata from epoch and slot for a given slot width
//  tag_unpack()    : split mdata back into epoch and slot for a given slot width
package rd_rob_pkg;

    localparam int ROB_EPOCH_W = 2;
    localparam int ROB_TAG_W   = 16;
    localparam int ROB_SLOT_W  = ROB_TAG_W - ROB_EPOCH_W;

    typedef logic [ROB_EPOCH_W-1:0] t_rob_epoch;
    typedef logic [ROB_SLOT_W-1:0]  t_rob_slot;
    typedef logic [ROB_TAG_W-1:0]   t_rob_tag;

    typedef struct packed {
        logic       foreign;
        t_rob_epoch epoch;
        t_rob_slot  slot;
    } t_rob_tag_fields;

    // The slot occupies the low log_depth bits and the epoch sits directly
    // above it, so the layout tracks the configured buffer depth.
    function automatic t_rob_tag tag_pack(input t_rob_epoch epoch, input t_rob_slot slot,
                                          input int log_depth);
        t_rob_slot mask;
        mask = t_rob_slot'((1 << log_depth) - 1);
        return t_rob_tag'(slot & mask) | (t_rob_tag'(epoch) << log_depth);
    endfunction

    // A tag with any bit set above the epoch was never issued by this block.
    function automatic t_rob_tag_fields tag_unpack(input t_rob_tag tag, input int log_depth);
        t_rob_tag_fields f;
        t_rob_slot       mask;
        mask      = t_rob_slot'((1 << log_depth) - 1);
        f.slot    = t_rob_slot'(tag) & mask;
        f.epoch   = t_rob_epoch'(tag >> log_depth);
        f.foreign = |(tag >> (log_depth + ROB_EPOCH_W));
        return f;
    endfunction

endpackage

// File: rtl/rd_reorder_buffer_if.sv
// rtl/rd_reorder_buffer_if.sv - request, c0 channel and in-order output signals of the read reorder buffer
//  in_req_*   : consumer line-read requests (valid/ready)
//  cci_req_*  : c0 read request issue towards MPF, gated by cci_req_avail
//  cci_rsp_*  : c0 read responses, any order, identified by mdata
//  out_*      : in-order lines back to the consumer (valid/ready)
//  master     : environment side (consumer + MPF)
//  slave      : reorder buffer side
interface rd_reorder_buffer_if #(
    parameter int ADDR_W = 48,
    parameter int DATA_W = 512,
    parameter int TAG_W  = 16
);
    logic              in_req_valid;
    logic [ADDR_W-1:0] in_req_addr;
    logic              in_req_ready;

    logic              cci_req_avail;
    logic              cci_req_en;
    logic [ADDR_W-1:0] cci_req_addr;
    logic [TAG_W-1:0]  cci_req_mdata;

    logic              cci_rsp_valid;
    logic [TAG_W-1:0]  cci_rsp_mdata;
    logic [DATA_W-1:0] cci_rsp_data;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_req_valid, in_req_addr, cci_req_avail,
        output cci_rsp_valid, cci_rsp_mdata, cci_rsp_data, out_ready,
        input  in_req_ready, cci_req_en, cci_req_addr, cci_req_mdata,
        input  out_valid, out_addr, out_data
    );

    modport slave (
        input  in_req_valid, in_req_addr, cci_req_avail,
        input  cci_rsp_valid, cci_rsp_mdata, cci_rsp_data, out_ready,
        output in_req_ready, cci_req_en, cci_req_addr, cci_req_mdata,
        output out_valid, out_addr, out_data
    );
endinterface

// File: rtl/rob_line_ram.sv
// rtl/rob_line_ram.sv - DEPTH x W storage, one synchronous write port, one asynchronous read port
//  clk   : clock
//  we    : write enable
//  waddr : write slot
//  wdata : write word
//  raddr : read slot
//  rdata : word at raddr, combinational
module rob_line_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rd_reorder_buffer.sv
// rtl/rd_reorder_buffer.sv - reorders out-of-order c0 read responses back into request order
//  clk, reset   : clock, synchronous active-high reset
//  flush        : soft flush; drops every in-flight read and advances the epoch
//  bus          : slave side of rd_reorder_buffer_if (requests, c0 issue/response, output)
//  outstanding  : allocated slots, including a line held in the output register
//  err_spurious : sticky, a current-epoch response hit a slot that was not pending
module rd_reorder_buffer
    import rd_rob_pkg::*;
#(
    parameter int ADDR_W    = 48,
    parameter int DATA_W    = 512,
    parameter int TAG_W     = 16,
    parameter int LOG_DEPTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    rd_reorder_buffer_if.slave   bus,
    output logic [LOG_DEPTH:0]   outstanding,
    output logic                 err_spurious
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    typedef logic [LOG_DEPTH-1:0] t_ptr;

    t_ptr              wr_ptr;
    t_ptr              rd_ptr;
    logic [LOG_DEPTH:0] count;
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  valid_vec;
    t_rob_epoch        epoch;

    logic              accept;
    logic              pop;
    logic              load;
    logic              rsp_match;
    logic              rsp_hit;
    logic              rsp_spurious;
    t_rob_tag_fields   rsp_fields;
    t_ptr              rsp_slot;
    logic [DATA_W-1:0] data_rdata;
    logic [ADDR_W-1:0] addr_rdata;

    // count never exceeds DEPTH, so its top bit alone means "full".
    assign bus.in_req_ready = bus.cci_req_avail && !count[LOG_DEPTH] && !flush;
    assign accept           = bus.in_req_valid && bus.in_req_ready;
    assign pop              = bus.out_valid && bus.out_ready;
    assign load             = valid_vec[rd_ptr] && (!bus.out_valid || bus.out_ready) && !flush;

    assign rsp_fields = tag_unpack(t_rob_tag'(bus.cci_rsp_mdata), LOG_DEPTH);
    assign rsp_slot   = t_ptr'(rsp_fields.slot);

    // Responses from an older epoch (pre-flush reads still in MPF) or with a
    // tag this block never produced are dropped without raising an error.
    assign rsp_match    = bus.cci_rsp_valid && !flush && !rsp_fields.foreign &&
                          (rsp_fields.epoch == epoch) &&
                          ((rsp_fields.slot >> LOG_DEPTH) == '0);
    assign rsp_hit      = rsp_match && pending[rsp_slot];
    assign rsp_spurious = rsp_match && !pending[rsp_slot];

    assign outstanding  = count;

    rob_line_ram #(.DEPTH(DEPTH), .W(DATA_W), .AW(LOG_DEPTH)) u_data_ram (
        .clk   (clk),
        .we    (rsp_hit),
        .waddr (rsp_slot),
        .wdata (bus.cci_rsp_data),
        .raddr (rd_ptr),
        .rdata (data_rdata)
    );

    rob_line_ram #(.DEPTH(DEPTH), .W(ADDR_W), .AW(LOG_DEPTH)) u_addr_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (bus.in_req_addr),
        .raddr (rd_ptr),
        .rdata (addr_rdata)
    );

    // The issue strobe is deliberately not cleared by flush: a read accepted
    // just before the flush still goes out, and its epoch retires the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.cci_req_en <= 1'b0;
        end else begin
            bus.cci_req_en <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            bus.cci_req_addr  <= bus.in_req_addr;
            bus.cci_req_mdata <= TAG_W'(tag_pack(epoch, t_rob_slot'(wr_ptr), LOG_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            bus.out_addr <= addr_rdata;
            bus.out_data <= data_rdata;
        end
    end

    // A slot cannot be both accepted and responded to in one cycle (it is
    // only pending after acceptance), and a loadable rd_ptr slot is never
    // pending, so the per-bit updates below never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pending       <= '0;
            valid_vec     <= '0;
            epoch         <= '0;
            bus.out_valid <= 1'b0;
            err_spurious  <= 1'b0;
        end else if (flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pending       <= '0;
            valid_vec     <= '0;
            epoch         <= epoch + 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            if (accept) begin
                pending[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (rsp_hit) begin
                pending[rsp_slot]   <= 1'b0;
                valid_vec[rsp_slot] <= 1'b1;
            end
            if (rsp_spurious) begin
                err_spurious <= 1'b1;
            end
            if (load) begin
                valid_vec[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
                bus.out_valid     <= 1'b1;
            end else if (pop) begin
                bus.out_valid     <= 1'b0;
            end
            // The slot is recycled at load, but the line keeps counting until
            // the consumer actually takes it from the output register.
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
